res_buffer_ctrl: RTL and testbench
==================================

// Module: res_buffer_ctrl
// PURPOSE
//  Sequences the NPU result buffer (single address port, sync write, async read) per output tile.
//  FILL: accepts results from the PE array over valid/ready and writes them to consecutive addresses from 0.
//  DRAIN: reads the same addresses back in order and streams them to the output/writeback path over valid/ready.
//  The buffer has one address port, so FILL and DRAIN are mutually exclusive.
// PARAMETERS
//  BIT_DEPTH   8   width of one result word
//  ADDR_WIDTH  10  buffer address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  clk          in   1             clock, all state on posedge
//  rst_n        in   1             asynchronous, active-low reset
//  start        in   1             begin a tile; sampled only in IDLE
//  abort        in   1             synchronous abort of the current tile
//  tile_len     in   ADDR_WIDTH+1  results per tile; latched on accepted start
//  res_valid    in   1             PE result valid
//  res_data     in   BIT_DEPTH     PE result word
//  res_ready    out  1             controller accepts res_data
//  out_valid    out  1             drained word valid
//  out_data     out  BIT_DEPTH     drained word
//  out_ready    in   1             downstream accepts out_data
//  buf_wr_en    out  1             buffer write enable
//  buf_addr     out  ADDR_WIDTH    buffer address (shared by write and read)
//  buf_wr_data  out  BIT_DEPTH     buffer write data
//  buf_rd_data  in   BIT_DEPTH     buffer async read data at buf_addr
//  busy         out  1             state != IDLE
//  done         out  1             1-cycle pulse: tile fully drained
//  cfg_err      out  1             1-cycle pulse: start rejected, tile_len > DEPTH
// BEHAVIOUR
//  State: IDLE, FILL, DRAIN.
//   - ptr: ADDR_WIDTH+1 bits.
//   - len: latched tile_len.
//  Reset (rst_n=0, async):
//   - State IDLE; ptr, len, done, cfg_err = 0.
//   - All outputs 0; buf_addr = 0.
//  IDLE:
//   - start and 0 < tile_len <= DEPTH: len <= tile_len, ptr <= 0, go to FILL next cycle.
//   - start and tile_len == 0: done pulses next cycle, stay IDLE.
//   - start and tile_len > DEPTH: cfg_err pulses next cycle, stay IDLE, nothing latched.
//  FILL:
//   - res_ready = 1.
//   - buf_wr_en = res_valid; buf_addr = ptr[ADDR_WIDTH-1:0]; buf_wr_data = res_data (combinational).
//   - Each res_valid && res_ready beat: ptr++.
//   - Beat with ptr == len-1: ptr <= 0, go to DRAIN next cycle.
//  DRAIN:
//   - out_valid = 1; buf_addr = ptr[ADDR_WIDTH-1:0]; out_data = buf_rd_data (0-cycle read latency).
//   - Each out_valid && out_ready beat: ptr++.
//   - While out_ready = 0, out_data stays stable because buf_addr is held.
//   - Beat with ptr == len-1: go to IDLE, done = 1 for exactly the next cycle.
//  Outside their states: res_ready, buf_wr_en, out_valid = 0; buf_wr_data, out_data = 0.
//  Latency, start to first res_ready: 1 cycle. Last write to first out_valid: 1 cycle.
//  Tile length and addressing:
//   - tile_len == DEPTH uses every address 0..DEPTH-1; no address wrap within a tile.
//   - ptr never exceeds len.
//  Ignored inputs:
//   - start is ignored while busy.
//   - tile_len changes after acceptance have no effect.
//  abort:
//   - In FILL or DRAIN: go to IDLE next cycle, ptr <= 0, no done pulse.
//   - The beat in the abort cycle still completes (write or handshake) if valid && ready.
//   - abort in IDLE has no effect; abort takes priority over start in the same cycle.
//  rst_n low mid-tile: immediate IDLE; buffer contents untouched but treated as stale.
// TESTING
//  T1 tile_len=4, res 0x11,0x22,0x33,0x44 back-to-back, out_ready=1:
//     -> writes at addr 0..3; out_data 0x11..0x44 on 4 consecutive cycles; one done pulse.
//  T2 tile_len=3, res_valid gaps, out_ready toggling 1,0,0,1,1:
//     -> out_data held stable while stalled; exactly 3 out handshakes in order; done after the 3rd.
//  T3 tile_len=DEPTH (1024), incrementing data:
//     -> last write at addr 1023; drain returns 0..1023 in order (mod 256); no wrap.
//  T4 tile_len=0 -> done pulse, busy stays 0.
//     tile_len=1025 -> cfg_err pulse, no FILL, no done.
//  T5 start pulsed during FILL with tile_len=7 -> ignored; original len=2 tile completes.
//  T6 abort after 2 of 5 writes -> IDLE next cycle, no done;
//     rst_n low mid-DRAIN -> out_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/res_buffer_ctrl_if.sv
// res_buffer_ctrl_if: result stream, drain stream and buffer port of the result buffer controller
//   res_valid/res_data/res_ready      PE result stream (controller is the sink)
//   out_valid/out_data/out_ready      drained word stream (controller is the source)
//   buf_wr_en/buf_addr/buf_wr_data    single-port buffer write side and shared address
//   buf_rd_data                       buffer async read data at buf_addr
//   modport master: controller side; modport slave: PE array / downstream / buffer side
interface res_buffer_ctrl_if #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  res_valid;
    logic                  res_ready;
    logic [BIT_DEPTH-1:0]  res_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIT_DEPTH-1:0]  out_data;
    logic                  buf_wr_en;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [BIT_DEPTH-1:0]  buf_wr_data;
    logic [BIT_DEPTH-1:0]  buf_rd_data;

    modport master (
        input  res_valid, res_data, out_ready, buf_rd_data,
        output res_ready, out_valid, out_data, buf_wr_en, buf_addr, buf_wr_data
    );

    modport slave (
        output res_valid, res_data, out_ready, buf_rd_data,
        input  res_ready, out_valid, out_data, buf_wr_en, buf_addr, buf_wr_data
    );
endinterface

// File: rtl/res_buffer_ctrl.sv
// res_buffer_ctrl: sequences one output tile through the result buffer, FILL from the PE array then DRAIN to writeback
//   clk       clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   start     begin a tile, sampled only in IDLE
//   abort     drop the current tile, back to IDLE without done
//   tile_len  results per tile, latched on an accepted start
//   bus       result stream, drain stream and buffer port (master side)
//   busy      a tile is in FILL or DRAIN
//   done      1-cycle pulse when a tile is fully drained (or started with length 0)
//   cfg_err   1-cycle pulse when start is rejected because tile_len exceeds the buffer
module res_buffer_ctrl #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   tile_len,
    res_buffer_ctrl_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] ptr, ptr_nxt;
    logic [ADDR_WIDTH:0] len, len_nxt;
    logic                done_nxt, cfg_err_nxt;
    logic                fill, drain, last;

    assign fill  = state == FILL;
    assign drain = state == DRAIN;
    // ptr is one bit wider than the address so a full DEPTH tile compares without wrap
    assign last  = ptr == len - ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            len     <= '0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            len     <= len_nxt;
            done    <= done_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        len_nxt     = len;
        done_nxt    = 1'b0;
        cfg_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                // abort wins over start even though it otherwise does nothing in IDLE
                if (start && !abort) begin
                    if (tile_len == '0) begin
                        done_nxt = 1'b1;
                    end else if (tile_len > DEPTH) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        len_nxt   = tile_len;
                        ptr_nxt   = '0;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.res_valid) begin
                    ptr_nxt   = last ? '0 : ptr + ONE;
                    state_nxt = last ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    ptr_nxt   = last ? '0 : ptr + ONE;
                    state_nxt = last ? IDLE : DRAIN;
                    done_nxt  = last;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // the beat in the abort cycle still lands via the combinational outputs
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    assign busy            = state != IDLE;
    assign bus.res_ready   = fill;
    assign bus.buf_wr_en   = fill && bus.res_valid;
    assign bus.buf_wr_data = fill ? bus.res_data : '0;
    // address held while DRAIN stalls keeps the async read data stable
    assign bus.buf_addr    = (fill || drain) ? ptr[ADDR_WIDTH-1:0] : '0;
    assign bus.out_valid   = drain;
    assign bus.out_data    = drain ? bus.buf_rd_data : '0;

    ptr_in_tile: assert property (@(posedge clk) disable iff (!rst_n) state == IDLE || ptr < len);
    single_pulse: assert property (@(posedge clk) disable iff (!rst_n) !(done && cfg_err));
endmodule

// File: tb/tb_res_buffer_ctrl.sv
// tb_res_buffer_ctrl: random and directed tiles against a queue scoreboard of accepted results
module tb_res_buffer_ctrl;
    localparam int BW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   tile_len = '0;
    logic          busy, done, cfg_err;

    res_buffer_ctrl_if #(.BIT_DEPTH(BW), .ADDR_WIDTH(AW)) bus();

    res_buffer_ctrl #(.BIT_DEPTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tile_len(tile_len),
        .bus(bus.master), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    logic [BW-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.buf_wr_en) mem[bus.buf_addr] <= bus.buf_wr_data;
    assign bus.buf_rd_data = mem[bus.buf_addr];

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_at = -1;
    int cfg_at = -1;
    int drain_left = 0;
    int stall_pct = 0;
    logic [BW-1:0] exp_q[$];
    bit rdy_pat[$];
    bit prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_pat.size() != 0 ? rdy_pat.pop_front() : (int'($urandom_range(99)) >= stall_pct);
        end
    end

    // monitor: done/cfg_err timing every cycle, drained words against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("done", 32'(done), 32'(cyc == done_at));
            chk("cfg_err", 32'(cfg_err), 32'(cyc == cfg_at));
            if (prev_stall && bus.out_valid) chk("out_hold", 32'(bus.out_data), 32'(prev_data));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %0h expected no output", bus.out_data);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
                drain_left--;
                if (drain_left == 0) done_at = cyc + 1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    task automatic start_tile(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        tile_len = (AW+1)'(n);
        if (n == 0) done_at = cyc + 1;
        if (n > DEPTH) cfg_at = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // dmode: 0 random, 1 address-incrementing, 2 multiples of 0x11
    task automatic fill(input int n, input int gap, input int dmode, input bit poke, input bit push, input bit pat);
        int i = 0;
        while (i < n) begin
            bus.res_valid = int'($urandom_range(99)) >= gap;
            bus.res_data = dmode == 1 ? BW'(i) : dmode == 2 ? BW'((i + 1) * 17) : BW'($urandom);
            if (poke && i == 1) begin
                start = 1'b1;
                tile_len = (AW+1)'(7);
            end
            @(negedge clk);
            chk("res_ready", 32'(bus.res_ready), 32'd1);
            if (bus.res_valid) begin
                chk("wr_en", 32'(bus.buf_wr_en), 32'd1);
                chk("wr_addr", 32'(bus.buf_addr), 32'(i));
                chk("wr_data", 32'(bus.buf_wr_data), 32'(bus.res_data));
                if (push) exp_q.push_back(bus.res_data);
                i++;
                if (i == n && pat) begin
                    rdy_pat.push_back(1'b1);
                    rdy_pat.push_back(1'b0);
                    rdy_pat.push_back(1'b0);
                    rdy_pat.push_back(1'b1);
                    rdy_pat.push_back(1'b1);
                end
            end else begin
                chk("wr_en_gap", 32'(bus.buf_wr_en), 32'd0);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            bus.res_valid = 1'b0;
        end
    endtask

    task automatic run_tile(input int n, input int gap, input int stall, input int dmode, input bit poke, input bit pat);
        int guard = 0;
        stall_pct = stall;
        if (n > 0 && n <= DEPTH) drain_left = n;
        start_tile(n);
        if (n == 0 || n > DEPTH) begin
            chk("rej_busy", 32'(busy), 32'd0);
            chk("rej_res_ready", 32'(bus.res_ready), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            chk("rej_busy_later", 32'(busy), 32'd0);
        end else begin
            chk("fill_latency", 32'(bus.res_ready), 32'd1);
            chk("fill_busy", 32'(busy), 32'd1);
            fill(n, gap, dmode, poke, 1'b1, pat);
            chk("drain_latency", 32'(bus.out_valid), 32'd1);
            chk("drain_res_ready", 32'(bus.res_ready), 32'd0);
            while ((drain_left > 0 || cyc <= done_at) && guard < 20 * n + 100) begin
                @(posedge clk);
                guard++;
            end
            #1;
            if (guard >= 20 * n + 100) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: %0d words still pending, expected 0", drain_left);
                drain_left = 0;
                exp_q.delete();
            end
            chk("end_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_res_ready", 32'(bus.res_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_wr_en", 32'(bus.buf_wr_en), 32'd0);
        chk("rst_addr", 32'(bus.buf_addr), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_wr_data", 32'(bus.buf_wr_data), 32'd0);
        rst_n = 1'b1;

        run_tile(4, 0, 0, 2, 1'b0, 1'b0);
        run_tile(3, 50, 0, 0, 1'b0, 1'b1);
        run_tile(DEPTH, 0, 0, 1, 1'b0, 1'b0);
        run_tile(0, 0, 0, 0, 1'b0, 1'b0);
        run_tile(DEPTH + 1, 0, 0, 0, 1'b0, 1'b0);
        run_tile(2, 0, 0, 0, 1'b1, 1'b0);
        run_tile(1, 0, 0, 0, 1'b0, 1'b0);
        for (int t = 0; t < 15; t++) run_tile(int'($urandom_range(1, 40)), 30, 30, 0, 1'b0, 1'b0);

        // abort after 2 of 5 writes
        stall_pct = 0;
        start_tile(5);
        fill(2, 0, 0, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_ready", 32'(bus.res_ready), 32'd0);
        repeat (3) @(posedge clk);

        // abort beats start in IDLE
        #1;
        start = 1'b1;
        abort = 1'b1;
        tile_len = (AW+1)'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_vs_start", 32'(busy), 32'd0);

        // reset mid-DRAIN acts immediately
        stall_pct = 100;
        start_tile(3);
        fill(3, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_addr", 32'(bus.buf_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall_pct = 0;
        run_tile(5, 20, 20, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
